// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage: loads/stores over a req/ack data bus with stall
//
// Purpose:
//   Runs loads and stores against a variable-latency data-memory bus, stalls
//   the upstream pipeline while an access is outstanding, and produces the
//   write-back word plus a gated register-write enable for MEM/WB.
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-high reset
//   mem_isLoad/mem_isStore    access type from EX/MEM
//   mem_accessSize            00 byte, 01 half, 10/11 word
//   mem_isSignedLoad          sign-extend byte/half loads
//   mem_shouldWriteRegister   register-write enable from EX/MEM
//   mem_aluOutput             effective address or ALU result
//   mem_storeData             store source value
//   dmem_ack, dmem_rdata      bus completion and read data
//   dmem_req/we/addr/wdata/be registered bus request
//   stall                     freeze upstream pipeline registers
//   out_shouldWriteRegister   gated register-write enable to MEM/WB
//   out_memoryData            write-back data to MEM/WB
//   misaligned, busError      one-cycle fault flags

module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_isLoad,
  input  logic        mem_isStore,
  input  logic [1:0]  mem_accessSize,
  input  logic        mem_isSignedLoad,
  input  logic        mem_shouldWriteRegister,
  input  logic [31:0] mem_aluOutput,
  input  logic [31:0] mem_storeData,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        stall,
  output logic        out_shouldWriteRegister,
  output logic [31:0] out_memoryData,
  output logic        misaligned,
  output logic        busError
);

  // Counter value seen in the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_WAIT = 2'b01,
    STATE_DONE = 2'b10
  } stateType;

  stateType    state;
  stateType    nextState;

  logic [7:0]  waitCounter;
  logic [31:0] capturedData;
  logic        errorFlag;
  logic [1:0]  addrLow;
  logic [1:0]  sizeLatched;
  logic        signedLatched;
  logic        loadLatched;

  logic        isAccess;
  logic        isMisaligned;
  logic        issue;
  logic        timeoutHit;
  logic [31:0] issueWdata;
  logic [3:0]  issueBe;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadExtended;

  assign isAccess   = mem_isLoad | mem_isStore;
  assign timeoutHit = (waitCounter == TIMEOUT_LAST);

  // Size 11 is handled as a word, so bit 1 alone identifies word accesses.
  always_comb begin
    isMisaligned = 1'b0;
    if (mem_accessSize[1]) begin
      isMisaligned = (mem_aluOutput[1:0] != 2'b00);
    end else if (mem_accessSize == 2'b01) begin
      isMisaligned = mem_aluOutput[0];
    end
  end

  // Store data is replicated across all lanes; byte enables pick the lane.
  always_comb begin
    issueWdata = mem_storeData;
    issueBe    = 4'b1111;
    case (mem_accessSize)
      2'b00: begin
        issueWdata = {4{mem_storeData[7:0]}};
        issueBe    = 4'b0001 << mem_aluOutput[1:0];
      end
      2'b01: begin
        issueWdata = {2{mem_storeData[15:0]}};
        issueBe    = mem_aluOutput[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        issueWdata = mem_storeData;
        issueBe    = 4'b1111;
      end
    endcase
  end

  // Lane selection uses the address bits latched at issue, not the live
  // EX/MEM value, so the result depends only on the access in flight.
  always_comb begin
    loadByte     = 8'h00;
    loadHalf     = 16'h0000;
    loadExtended = dmem_rdata;
    case (addrLow)
      2'b00:   loadByte = dmem_rdata[7:0];
      2'b01:   loadByte = dmem_rdata[15:8];
      2'b10:   loadByte = dmem_rdata[23:16];
      default: loadByte = dmem_rdata[31:24];
    endcase
    loadHalf = addrLow[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (sizeLatched)
      2'b00:   loadExtended = {{24{signedLatched & loadByte[7]}}, loadByte};
      2'b01:   loadExtended = {{16{signedLatched & loadHalf[15]}}, loadHalf};
      default: loadExtended = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= STATE_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and stage outputs. The fault flags are masked by reset so
  // they read low while the stage is held in reset, whatever EX/MEM shows.
  always_comb begin
    nextState               = state;
    stall                   = 1'b0;
    issue                   = 1'b0;
    out_shouldWriteRegister = mem_shouldWriteRegister;
    out_memoryData          = mem_aluOutput;
    misaligned              = 1'b0;
    busError                = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (isAccess) begin
          out_shouldWriteRegister = 1'b0;
          if (isMisaligned) begin
            misaligned = ~reset;
          end else begin
            stall     = 1'b1;
            issue     = 1'b1;
            nextState = STATE_WAIT;
          end
        end
      end
      STATE_WAIT: begin
        stall                   = 1'b1;
        out_shouldWriteRegister = 1'b0;
        // Ack is tested first so a same-cycle ack beats the timeout.
        if (dmem_ack || timeoutHit) begin
          nextState = STATE_DONE;
        end
      end
      STATE_DONE: begin
        if (loadLatched) begin
          out_memoryData = capturedData;
        end
        out_shouldWriteRegister = mem_shouldWriteRegister & ~errorFlag;
        busError                = errorFlag & ~reset;
        // Always leave DONE so the held EX/MEM instruction is not reissued.
        nextState               = STATE_IDLE;
      end
      default: begin
        nextState = STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_be       <= 4'h0;
      waitCounter   <= 8'h0;
      capturedData  <= 32'h0;
      errorFlag     <= 1'b0;
      addrLow       <= 2'b00;
      sizeLatched   <= 2'b00;
      signedLatched <= 1'b0;
      loadLatched   <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (issue) begin
            dmem_req      <= 1'b1;
            dmem_we       <= mem_isStore;
            dmem_addr     <= {mem_aluOutput[31:2], 2'b00};
            dmem_wdata    <= issueWdata;
            dmem_be       <= issueBe;
            waitCounter   <= 8'h0;
            errorFlag     <= 1'b0;
            addrLow       <= mem_aluOutput[1:0];
            sizeLatched   <= mem_accessSize;
            signedLatched <= mem_isSignedLoad;
            loadLatched   <= mem_isLoad;
          end
        end
        STATE_WAIT: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            errorFlag <= 1'b0;
            if (loadLatched) begin
              capturedData <= loadExtended;
            end
          end else if (timeoutHit) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            errorFlag <= 1'b1;
          end else begin
            waitCounter <= waitCounter + 8'h1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb/tb_memory_access_stage.sv - scoreboard bench for memory_access_stage

module tb_memory_access_stage;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_isLoad = 1'b0;
  logic        mem_isStore = 1'b0;
  logic [1:0]  mem_accessSize = 2'b00;
  logic        mem_isSignedLoad = 1'b0;
  logic        mem_shouldWriteRegister = 1'b0;
  logic [31:0] mem_aluOutput = 32'h0;
  logic [31:0] mem_storeData = 32'h0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        stall;
  logic        out_shouldWriteRegister;
  logic [31:0] out_memoryData;
  logic        misaligned;
  logic        busError;

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock),
    .reset(reset),
    .mem_isLoad(mem_isLoad),
    .mem_isStore(mem_isStore),
    .mem_accessSize(mem_accessSize),
    .mem_isSignedLoad(mem_isSignedLoad),
    .mem_shouldWriteRegister(mem_shouldWriteRegister),
    .mem_aluOutput(mem_aluOutput),
    .mem_storeData(mem_storeData),
    .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be),
    .stall(stall),
    .out_shouldWriteRegister(out_shouldWriteRegister),
    .out_memoryData(out_memoryData),
    .misaligned(misaligned),
    .busError(busError)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        wr;
    logic        mis;
    logic        berr;
    bit          checkData;
  } RetireExp;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } RequestExp;

  RetireExp  retireQ[$];
  RequestExp requestQ[$];
  int        checks = 0;
  int        failures = 0;
  logic      instValid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic driveNop();
    mem_isLoad              = 1'b0;
    mem_isStore             = 1'b0;
    mem_accessSize          = 2'b00;
    mem_isSignedLoad        = 1'b0;
    mem_shouldWriteRegister = 1'b0;
    mem_aluOutput           = 32'h0;
    mem_storeData           = 32'h0;
  endtask

  // Retire monitor: an instruction leaves MEM on any cycle where a valid
  // instruction is present and the stage is not stalling.
  initial begin : retireMonitor
    RetireExp e;
    forever begin
      @(negedge clock);
      if (!reset && instValid && !stall) begin
        if (retireQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected actual=retire required=none");
        end else begin
          e = retireQ.pop_front();
          if (e.checkData) check({e.name, "_data"}, out_memoryData, e.data);
          check({e.name, "_wr"}, 32'(out_shouldWriteRegister), 32'(e.wr));
          check({e.name, "_misaligned"}, 32'(misaligned), 32'(e.mis));
          check({e.name, "_busError"}, 32'(busError), 32'(e.berr));
        end
      end
    end
  end

  // Request monitor: compares the bus request on its first cycle high.
  initial begin : requestMonitor
    RequestExp r;
    logic prevReq;
    prevReq = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prevReq = 1'b0;
      end else begin
        if (dmem_req && !prevReq) begin
          if (requestQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL request_unexpected actual=0x%08h required=none", dmem_addr);
          end else begin
            r = requestQ.pop_front();
            check({r.name, "_req_we"}, 32'(dmem_we), 32'(r.we));
            check({r.name, "_req_addr"}, dmem_addr, r.addr);
            check({r.name, "_req_wdata"}, dmem_wdata, r.wdata);
            check({r.name, "_req_be"}, 32'(dmem_be), 32'(r.be));
          end
        end
        prevReq = dmem_req;
      end
    end
  end

  task automatic pushRequest(input string name, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    RequestExp r;
    r.name = name; r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    requestQ.push_back(r);
  endtask

  // Issues one instruction into MEM at the next edge, plays the memory with
  // ack on WAIT cycle ackOn (0 = never), and holds it until it retires.
  task automatic runOp(
    input string       name,
    input logic        isLoad,
    input logic        isStore,
    input logic [1:0]  size,
    input logic        isSigned,
    input logic        swr,
    input logic [31:0] alu,
    input logic [31:0] sd,
    input int          ackOn,
    input logic [31:0] rdata,
    input int          expStall,
    input bit          expReq,
    input logic [31:0] reqAddr,
    input logic [31:0] reqWdata,
    input logic [3:0]  reqBe,
    input logic [31:0] expData,
    input logic        expWr,
    input logic        expMis,
    input logic        expBerr,
    input bit          checkData
  );
    RetireExp e;
    int stallCount;
    int waitIdx;
    bit done;
    @(posedge clock);
    #1;
    mem_isLoad              = isLoad;
    mem_isStore             = isStore;
    mem_accessSize          = size;
    mem_isSignedLoad        = isSigned;
    mem_shouldWriteRegister = swr;
    mem_aluOutput           = alu;
    mem_storeData           = sd;
    instValid               = 1'b1;
    e.name = name; e.data = expData; e.wr = expWr; e.mis = expMis;
    e.berr = expBerr; e.checkData = checkData;
    retireQ.push_back(e);
    if (expReq) pushRequest(name, isStore, reqAddr, reqWdata, reqBe);
    stallCount = 0;
    waitIdx    = 0;
    done       = 1'b0;
    while (!done) begin
      @(negedge clock);
      if (!stall) begin
        done = 1'b1;
      end else begin
        stallCount++;
        if (stallCount > 40) begin
          checks++;
          failures++;
          $display("FAIL %s_retire_timeout actual=%0d required=%0d", name, stallCount, expStall);
          done = 1'b1;
        end else begin
          @(posedge clock);
          #1;
          waitIdx++;
          dmem_ack   = (ackOn != 0) && (waitIdx == ackOn);
          dmem_rdata = rdata;
        end
      end
    end
    check({name, "_stall_cycles"}, 32'(stallCount), 32'(expStall));
    check({name, "_req_low_at_retire"}, 32'(dmem_req), 32'h0);
    dmem_ack = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    driveNop();
    reset = 1'b1;
    #12;
    check("reset_req", 32'(dmem_req), 32'h0);
    check("reset_we", 32'(dmem_we), 32'h0);
    check("reset_be", 32'(dmem_be), 32'h0);
    check("reset_addr", dmem_addr, 32'h0);
    check("reset_wdata", dmem_wdata, 32'h0);
    check("reset_busError", 32'(busError), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    // A misaligned word load presented during reset must not flag.
    mem_isLoad = 1'b1; mem_accessSize = 2'b10; mem_aluOutput = 32'h6;
    #1;
    check("reset_misaligned_masked", 32'(misaligned), 32'h0);
    driveNop();
    @(negedge clock);
    reset = 1'b0;

    // Reset while a word load at 0x3000 is waiting on the bus.
    @(posedge clock);
    #1;
    mem_isLoad = 1'b1; mem_accessSize = 2'b10; mem_aluOutput = 32'h3000;
    mem_shouldWriteRegister = 1'b1; instValid = 1'b1;
    pushRequest("t1", 1'b0, 32'h3000, 32'h0, 4'hF);
    @(negedge clock);
    check("t1_stall_issue", 32'(stall), 32'h1);
    @(posedge clock);
    @(negedge clock);
    check("t1_req_in_wait", 32'(dmem_req), 32'h1);
    #2;
    reset = 1'b1;
    instValid = 1'b0;
    driveNop();
    #1;
    check("t1_req_drop_async", 32'(dmem_req), 32'h0);
    check("t1_no_writeback", 32'(out_shouldWriteRegister), 32'h0);
    check("t1_stall_in_reset", 32'(stall), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    //    name    ld    st    sz     sg    swr   alu           sd            ack rdata         stl req  rAddr         rWdata        rBe      data          wr    mis   berr  chk
    runOp("t2",   1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h12345678, 32'h0,        0,  32'h0,        0,  0,   32'h0,        32'h0,        4'h0,    32'h12345678, 1'b1, 1'b0, 1'b0, 1);
    runOp("t3",   1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h00001003, 32'h0,        2,  32'h80FF0011, 3,  1,   32'h00001000, 32'h0,        4'b1000, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0, 1);
    runOp("t4",   1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h00002002, 32'h1234ABCD, 1,  32'h0,        2,  1,   32'h00002000, 32'hABCDABCD, 4'b1100, 32'h00002002, 1'b0, 1'b0, 1'b0, 1);
    runOp("t5",   1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00000006, 32'h0,        0,  32'h0,        0,  0,   32'h0,        32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 1'b0, 0);
    runOp("t6a",  1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00004000, 32'h0,        0,  32'h11111111, 5,  1,   32'h00004000, 32'h0,        4'hF,    32'h0,        1'b0, 1'b0, 1'b1, 0);
    runOp("t6b",  1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00004004, 32'h0,        4,  32'hDEADBEEF, 5,  1,   32'h00004004, 32'h0,        4'hF,    32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1);
    runOp("e1",   1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h00005002, 32'h0,        1,  32'h87654321, 2,  1,   32'h00005000, 32'h0,        4'b1100, 32'h00008765, 1'b1, 1'b0, 1'b0, 1);
    runOp("e2",   1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFF5A, 3,  32'h0,        4,  1,   32'h00000000, 32'h5A5A5A5A, 4'b0010, 32'h00000001, 1'b0, 1'b0, 1'b0, 1);
    runOp("e3",   1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'h00000000, 32'h0,        1,  32'h00008001, 2,  1,   32'h00000000, 32'h0,        4'b0011, 32'hFFFF8001, 1'b1, 1'b0, 1'b0, 1);
    runOp("e4",   1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h00000010, 32'hCAFEF00D, 2,  32'h0,        3,  1,   32'h00000010, 32'hCAFEF00D, 4'hF,    32'h00000010, 1'b0, 1'b0, 1'b0, 1);
    runOp("e5",   1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 32'h00000003, 32'h0,        0,  32'h0,        0,  0,   32'h0,        32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 1'b0, 0);
    runOp("e6",   1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h00001002, 32'h0,        1,  32'h80FF0011, 2,  1,   32'h00001000, 32'h0,        4'b0100, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1);

    @(posedge clock);
    #1;
    driveNop();
    instValid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("retire_queue_empty", 32'(retireQ.size()), 32'h0);
    check("request_queue_empty", 32'(requestQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
MEM pipeline stage. It sits between the EX/MEM pipeline registers and the MEM/WB pipeline registers. It runs loads and stores against a data-memory bus that has a variable-latency request/acknowledge handshake, and it stalls the upstream pipeline while an access is outstanding. It produces the write-back data word and a gated register-write enable for MEM/WB, and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles without dmem_ack before the access is aborted with a bus error (range 2..255)

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_isLoad  in  1  instruction is a load (same signal as shouldWriteMemoryElseAluOutputToRegister)
mem_isStore  in  1  instruction is a store
mem_accessSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_isSignedLoad  in  1  sign-extend byte/half loads
mem_shouldWriteRegister  in  1  register-write enable from EX/MEM
mem_aluOutput  in  32  effective address for loads/stores; result for all other instructions
mem_storeData  in  32  rs2 value for stores (low bits significant)
dmem_ack  in  1  memory completes the request this cycle
dmem_rdata  in  32  read data, valid with dmem_ack
dmem_req  out  1  registered request
dmem_we  out  1  registered write enable
dmem_addr  out  32  registered word address (bits [1:0] forced 0)
dmem_wdata  out  32  registered lane-replicated store data
dmem_be  out  4  registered byte enables
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
out_shouldWriteRegister  out  1  gated register-write enable to MEM/WB
out_memoryData  out  32  write-back data to MEM/WB
misaligned  out  1  one-cycle misaligned-access flag
busError  out  1  one-cycle timeout flag

Behaviour:
- Reset is asynchronous and active-high. While reset is high: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata = 0; timeout counter = 0; captured data register = 0; misaligned = 0; busError = 0. An access in flight is dropped with no write-back, and dmem_req falls immediately.
- Access: access = mem_isLoad | mem_isStore.
- Misaligned condition: word with addr[1:0] != 0, or half with addr[0] != 0.
- State IDLE:
  - Non-access: stall = 0. out_memoryData = mem_aluOutput and out_shouldWriteRegister = mem_shouldWriteRegister, both combinational (zero latency).
  - Aligned access: stall = 1 and out_shouldWriteRegister = 0 (bubble). Register dmem_req = 1, dmem_we = mem_isStore, addr, wdata and be. Clear the counter. Next state WAIT.
  - Misaligned access: no request, stall = 0, out_shouldWriteRegister = 0, misaligned = 1 for this cycle only (combinational).
- State WAIT:
  - stall = 1, out_shouldWriteRegister = 0. Request outputs are held stable. dmem_ack is ignored in every state except WAIT.
  - On dmem_ack: deassert dmem_req/dmem_we at the edge. For a load, capture the extracted and extended dmem_rdata. Next state DONE, with no error.
  - No ack: increment the counter. If the counter reaches TIMEOUT_CYCLES-1 without an ack, deassert dmem_req and go to DONE with an error flag. Timeout therefore fires after exactly TIMEOUT_CYCLES WAIT cycles.
- State DONE:
  - stall = 0, so EX/MEM advances at the end of this cycle.
  - out_memoryData = captured data for a load, mem_aluOutput for a store.
  - out_shouldWriteRegister = mem_shouldWriteRegister & !error.
  - busError = error for this cycle. Next state IDLE unconditionally, so the same instruction is never reissued.
- Minimum memory-op latency: 3 cycles (IDLE issue, one WAIT with ack, DONE). Back-to-back memory ops go DONE -> IDLE -> WAIT.
- Store lanes (little-endian):
  - byte: wdata = {4{sd[7:0]}}, be = 0001 << addr[1:0]
  - half: wdata = {2{sd[15:0]}}, be = 0011 << addr[1:0] (addr[1] selects 0011/1100)
  - word: wdata = sd, be = 1111
- Load extraction: select byte/half by addr[1:0] (addr latched at issue), then zero- or sign-extend per mem_isSignedLoad. Word loads pass through.
- Simultaneous dmem_ack and timeout in the same WAIT cycle: the ack wins and no error is raised.

Test Plan:
1. Reset asserted mid-WAIT (dmem_req = 1) -> dmem_req = 0 within the same cycle. Next op starts clean in IDLE, with no write-back of the aborted load.
2. Non-access, aluOutput = 0x12345678, shouldWriteRegister = 1 -> same cycle: stall = 0, out_memoryData = 0x12345678, out_shouldWriteRegister = 1.
3. Signed byte load at addr 0x1003, ack after 2 WAIT cycles with rdata = 0x80FF_0011:
   - stall high for 3 cycles; dmem_addr = 0x1000
   - DONE: out_memoryData = 0xFFFFFF80, write enable 1
4. Half store of 0xABCD at addr 0x2002, ack on the 1st WAIT cycle -> dmem_we = 1, dmem_be = 1100, dmem_wdata = 0xABCDABCD. DONE: out_shouldWriteRegister = 0.
5. Word load at addr 0x0006 -> misaligned = 1 for one cycle, dmem_req stays 0, stall = 0, out_shouldWriteRegister = 0.
6. Word load, ack never asserted, TIMEOUT_CYCLES = 4 -> dmem_req drops after 4 WAIT cycles. DONE: busError = 1, out_shouldWriteRegister = 0, then IDLE. Repeat with ack on the 4th WAIT cycle -> normal completion, busError = 0.
